// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_port_arbiter: shares one memory port between instruction fetch and the |
// | data stage. One outstanding transaction, data priority, fetch anti-starve. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_if_flush,
  output logic                o_if_ack,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_dm_req,
  input  logic                i_dm_we,
  input  logic [DATA_W/8-1:0] i_dm_be,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  output logic                o_dm_ack,
  output logic [DATA_W-1:0]   o_dm_rdata,
  output logic                o_if_stall,
  output logic                o_dm_stall,
  output logic                o_mem_valid,
  input  logic                i_mem_ready,
  output logic                o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);
  localparam logic       c_own_if       = 1'b0;
  localparam logic       c_own_dm       = 1'b1;

  state_t                r_state;
  logic                  r_owner;
  logic                  r_drop;
  logic [3:0]            r_streak;
  logic                  r_if_ack;
  logic                  r_dm_ack;
  logic [DATA_W-1:0]     r_if_rdata;
  logic [DATA_W-1:0]     r_dm_rdata;
  logic                  r_mem_valid;
  logic                  r_mem_we;
  logic [DATA_W/8-1:0]   r_mem_be;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;

  logic w_if_elig;
  logic w_dm_elig;
  logic w_grant_if;
  logic w_grant_dm;
  logic w_flush_own;
  logic w_drop_now;

  // A requester whose ack is still high has already been served this cycle.
  assign w_if_elig   = i_if_req & ~r_if_ack & ~i_if_flush;
  assign w_dm_elig   = i_dm_req & ~r_dm_ack;
  assign w_grant_if  = w_if_elig & (~w_dm_elig | (r_streak == c_starve_limit));
  assign w_grant_dm  = w_dm_elig & ~w_grant_if;
  assign w_flush_own = i_if_flush & (r_owner == c_own_if);
  // A flush arriving together with the response still discards it.
  assign w_drop_now  = r_drop | i_if_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner     <= c_own_if;
      r_drop      <= 1'b0;
      r_streak    <= 4'd0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_if) begin
            r_owner     <= c_own_if;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '1;
            r_mem_addr  <= i_if_addr;
            r_mem_wdata <= '0;
            r_mem_valid <= 1'b1;
            r_streak    <= 4'd0;
            r_state     <= S_ISSUE;
          end else if (w_grant_dm) begin
            r_owner     <= c_own_dm;
            r_mem_we    <= i_dm_we;
            r_mem_be    <= i_dm_be;
            r_mem_addr  <= i_dm_addr;
            r_mem_wdata <= i_dm_wdata;
            r_mem_valid <= 1'b1;
            r_state     <= S_ISSUE;
            if (!i_if_req)
              r_streak <= 4'd0;
            else if (r_streak != c_starve_limit)
              r_streak <= r_streak + 4'd1;
          end
        end
        S_ISSUE: begin
          if (w_flush_own)
            r_drop <= 1'b1;
          if (i_mem_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_mem_rvalid) begin
            r_state <= S_IDLE;
            if (r_owner == c_own_if) begin
              if (w_drop_now) begin
                r_drop <= 1'b0;
              end else begin
                r_if_rdata <= i_mem_rdata;
                r_if_ack   <= 1'b1;
              end
            end else begin
              r_dm_ack <= 1'b1;
              if (!r_mem_we)
                r_dm_rdata <= i_mem_rdata;
            end
          end else if (w_flush_own) begin
            r_drop <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_if_ack    = r_if_ack;
  assign o_dm_ack    = r_dm_ack;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_if_stall  = i_if_req & ~r_if_ack;
  assign o_dm_stall  = i_dm_req & ~r_dm_ack;
  assign o_mem_valid = r_mem_valid;
  assign o_mem_we    = r_mem_we;
  assign o_mem_be    = r_mem_be;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, dm_req, dm_we, mem_ready, mem_rvalid;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_be;
  logic        if_ack, dm_ack, if_stall, dm_stall, mem_valid, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail   = 0;

  // Bit g set means grant g of the starvation sequence must go to fetch.
  localparam logic [6:0] c_order = 7'b0010000;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_ack(if_ack), .o_if_rdata(if_rdata),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_be(dm_be), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .o_dm_ack(dm_ack), .o_dm_rdata(dm_rdata),
    .o_if_stall(if_stall), .o_dm_stall(dm_stall),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_we(mem_we),
    .o_mem_be(mem_be), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        is_fetch;
    logic [31:0] exp_addr;
    int          d_idx;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // Reset while a fetch waits for its response.
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    chk("t1_issue_valid", {31'b0, mem_valid}, 32'd1);
    tick();
    chk("t1_in_wait", {31'b0, busy}, 32'd1);
    rst = 1'b1; if_req = 1'b0;
    #1;
    chk("t1_rst_busy", {31'b0, busy}, 32'd0);
    chk("t1_rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("t1_rst_mem_addr", mem_addr, 32'd0);
    chk("t1_rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("t1_rst_if_ack", {31'b0, if_ack}, 32'd0);
    tick();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h0;
    #1;
    chk("t1_if_stall_c0", {31'b0, if_stall}, 32'd1);
    tick();
    chk("t1_c1_valid", {31'b0, mem_valid}, 32'd1);
    chk("t1_c1_addr", mem_addr, 32'h0);
    chk("t1_c1_we", {31'b0, mem_we}, 32'd0);
    chk("t1_c1_be", {28'b0, mem_be}, 32'hF);
    tick();
    chk("t1_c2_valid", {31'b0, mem_valid}, 32'd0);
    chk("t1_c2_busy", {31'b0, busy}, 32'd1);
    chk("t1_c2_no_ack", {31'b0, if_ack}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h00000013;
    tick();
    chk("t1_c3_ack", {31'b0, if_ack}, 32'd1);
    chk("t1_c3_rdata", if_rdata, 32'h00000013);
    chk("t1_c3_stall", {31'b0, if_stall}, 32'd0);
    chk("t1_c3_busy", {31'b0, busy}, 32'd0);
    if_req = 1'b0; mem_rvalid = 1'b0;
    tick();
    chk("t1_c4_ack_low", {31'b0, if_ack}, 32'd0);

    // Simultaneous fetch and load: data goes first.
    if_req = 1'b1; if_addr = 32'h44;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h100;
    #1;
    chk("t2_c0_if_stall", {31'b0, if_stall}, 32'd1);
    chk("t2_c0_dm_stall", {31'b0, dm_stall}, 32'd1);
    tick();
    chk("t2_c1_addr", mem_addr, 32'h100);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("t2_c3_dm_ack", {31'b0, dm_ack}, 32'd1);
    chk("t2_c3_dm_rdata", dm_rdata, 32'hDEADBEEF);
    chk("t2_c3_if_ack", {31'b0, if_ack}, 32'd0);
    chk("t2_c3_if_stall", {31'b0, if_stall}, 32'd1);
    dm_req = 1'b0; mem_rvalid = 1'b0;
    tick();
    chk("t2_c4_addr", mem_addr, 32'h44);
    tick();
    chk("t2_c5_if_stall", {31'b0, if_stall}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h00000013;
    tick();
    chk("t2_c6_if_ack", {31'b0, if_ack}, 32'd1);
    chk("t2_c6_if_rdata", if_rdata, 32'h00000013);
    chk("t2_c6_if_stall", {31'b0, if_stall}, 32'd0);
    chk("t2_c6_dm_rdata_hold", dm_rdata, 32'hDEADBEEF);
    if_req = 1'b0; mem_rvalid = 1'b0;
    tick();

    // Starvation: fetch held, data keeps coming; flush at data-ack cycles
    // keeps fetch out of the idle slot so the streak can build up.
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; d_idx = 0; dm_addr = 32'h200;
    for (int g = 0; g < 7; g++) begin
      is_fetch = c_order[g];
      exp_addr = is_fetch ? 32'h80 : 32'h200 + 32'(4 * d_idx);
      tick();
      chk($sformatf("t3_g%0d_valid", g), {31'b0, mem_valid}, 32'd1);
      chk($sformatf("t3_g%0d_addr", g), mem_addr, exp_addr);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h1000 + 32'(g);
      tick();
      mem_rvalid = 1'b0;
      if (is_fetch) begin
        chk($sformatf("t3_g%0d_if_ack", g), {31'b0, if_ack}, 32'd1);
        chk($sformatf("t3_g%0d_if_rdata", g), if_rdata, 32'h1004);
        if_addr = 32'h84;
      end else begin
        chk($sformatf("t3_g%0d_dm_ack", g), {31'b0, dm_ack}, 32'd1);
        d_idx++;
        dm_addr = 32'h200 + 32'(4 * d_idx);
        if (g < 6) begin
          if_flush = 1'b1;
          tick();
          if_flush = 1'b0;
        end
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    chk("t3_idle", {31'b0, busy}, 32'd0);

    // Fetch stalled by mem_ready, flushed while in ISSUE.
    if_req = 1'b1; if_addr = 32'h300; mem_ready = 1'b0;
    tick();
    chk("t4_c1_valid", {31'b0, mem_valid}, 32'd1);
    chk("t4_c1_addr", mem_addr, 32'h300);
    tick();
    chk("t4_c2_valid", {31'b0, mem_valid}, 32'd1);
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0; if_addr = 32'h400;
    chk("t4_c3_valid", {31'b0, mem_valid}, 32'd1);
    chk("t4_c3_addr", mem_addr, 32'h300);
    tick();
    chk("t4_c4_addr", mem_addr, 32'h300);
    mem_ready = 1'b1;
    tick();
    chk("t4_c5_valid_low", {31'b0, mem_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_rvalid = 1'b0;
    chk("t4_c6_no_ack", {31'b0, if_ack}, 32'd0);
    chk("t4_c6_rdata_hold", if_rdata, 32'h1004);
    chk("t4_c6_busy", {31'b0, busy}, 32'd0);
    tick();
    chk("t4_c7_addr", mem_addr, 32'h400);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h00500513;
    tick();
    chk("t4_c9_ack", {31'b0, if_ack}, 32'd1);
    chk("t4_c9_rdata", if_rdata, 32'h00500513);
    if_req = 1'b0; mem_rvalid = 1'b0;
    tick();

    // Store: command fields and ack timing; load data register untouched.
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h200; dm_wdata = 32'h1234ABCD;
    tick();
    chk("t5_valid", {31'b0, mem_valid}, 32'd1);
    chk("t5_we", {31'b0, mem_we}, 32'd1);
    chk("t5_be", {28'b0, mem_be}, 32'h3);
    chk("t5_addr", mem_addr, 32'h200);
    chk("t5_wdata", mem_wdata, 32'h1234ABCD);
    tick();
    chk("t5_no_early_ack", {31'b0, dm_ack}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    chk("t5_ack", {31'b0, dm_ack}, 32'd1);
    chk("t5_rdata_hold", dm_rdata, 32'h1006);
    dm_req = 1'b0; dm_we = 1'b0; mem_rvalid = 1'b0;
    tick();

    // Spurious responses in IDLE and ISSUE.
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    tick();
    chk("t6_idle_busy", {31'b0, busy}, 32'd0);
    chk("t6_idle_dm_ack", {31'b0, dm_ack}, 32'd0);
    chk("t6_idle_if_ack", {31'b0, if_ack}, 32'd0);
    chk("t6_idle_dm_rdata", dm_rdata, 32'h1006);
    mem_rvalid = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h104; mem_ready = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    tick();
    chk("t6_issue_valid", {31'b0, mem_valid}, 32'd1);
    chk("t6_issue_busy", {31'b0, busy}, 32'd1);
    chk("t6_issue_no_ack", {31'b0, dm_ack}, 32'd0);
    mem_rvalid = 1'b0; mem_ready = 1'b1;
    tick();
    chk("t6_wait_valid_low", {31'b0, mem_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    tick();
    chk("t6_ack", {31'b0, dm_ack}, 32'd1);
    chk("t6_rdata", dm_rdata, 32'h55);
    dm_req = 1'b0; mem_rvalid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between instruction fetch (IF) and the data stage (loads/stores driven by MemWriteD/ResultSrcD).
- Registered FSM with one outstanding transaction: arbitrate, issue with valid/ready, wait for response, acknowledge requester.
- Data has priority, plus an anti-starvation limit for fetch.
- Generates fetch/data stall signals for the hazard logic and supports discarding an in-flight fetch on a branch/jump flush.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte-enable width = DATA_W/8)
STARVE_LIMIT, 4, max consecutive data grants while if_req is pending before fetch is forced (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request; held with if_addr stable until if_ack
if_addr  in  ADDR_W  fetch address
if_flush  in  1  pulse: discard current/pending fetch
if_ack  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DATA_W  fetched instruction
dm_req  in  1  data request; held with fields stable until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_be  in  DATA_W/8  byte enables
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_ack  out  1  one-cycle pulse; dm_rdata valid for loads
dm_rdata  out  DATA_W  load data
if_stall  out  1  if_req & ~if_ack
dm_stall  out  1  dm_req & ~dm_ack
mem_valid  out  1  command valid
mem_ready  in  1  memory accepts command
mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  latched command fields
mem_rvalid  in  1  one response per accepted command (reads and writes)
mem_rdata  in  DATA_W  read data
busy  out  1  state != IDLE

Behaviour:
- Reset (async) forces:
  - State IDLE.
  - All outputs 0, including if_rdata, dm_rdata and the mem_* fields.
  - streak counter 0, owner 0, drop flag 0.
  - A transaction outstanding at reset is abandoned; memory is reset by the same rst.
- IDLE:
  - Eligible requesters: if_req & ~if_ack & ~if_flush; dm_req & ~dm_ack. A requester whose ack is high this cycle is masked.
  - Grant rule: data wins unless if eligible and streak == STARVE_LIMIT.
  - On grant: latch addr/we/be/wdata into the command register (fetch: we=0, be=all ones), record owner, go to ISSUE.
- ISSUE:
  - mem_valid = 1 with latched fields, held stable until mem_ready.
  - On mem_valid & mem_ready: go to WAIT; mem_valid deasserts next cycle.
  - No cancellation once in ISSUE.
- WAIT:
  - On mem_rvalid: capture mem_rdata into the owner's rdata register, pulse the owner's ack next cycle (registered), return to IDLE the same edge.
  - If owner is IF and drop = 1: no ack, rdata unchanged, drop cleared.
- mem_rvalid outside WAIT is ignored.
- Minimum latency: req seen in IDLE at cycle 0, ISSUE cycle 1 (ready=1), rvalid cycle 2, ack cycle 3. Back-to-back throughput is 1 transaction per 3 cycles with a zero-wait memory.
- Streak counter:
  - On data grant: if if_req was high at grant, increment, saturating at STARVE_LIMIT; else clear to 0.
  - On fetch grant: clear to 0.
- if_flush:
  - In IDLE: masks the fetch grant that cycle.
  - In ISSUE/WAIT with owner IF: sets drop.
  - With owner DM, or on a cycle where if_ack is already high: no effect, and the ack is not retracted.
- if_rdata/dm_rdata hold their value until the next acknowledged transaction of that requester.
- Stores also wait for mem_rvalid before dm_ack; dm_rdata is unchanged on a store.

Test Plan:
- Reset mid-WAIT, then release: all outputs 0, busy 0. A new if_req (addr 0x0) then acks at cycle 3 with mem_rdata 0x00000013 returned.
- if_req and dm_req (load 0x100) both arrive in cycle 0, memory zero-wait returning 0xDEADBEEF, then 0x13 → dm_ack cycle 3 (dm_rdata 0xDEADBEEF), if_ack cycle 6. if_stall is high cycles 0-5.
- if_req held with 6 consecutive data requests, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D. Streak clears after the fetch grant.
- Fetch issued with mem_ready low for 3 cycles: mem_valid and mem_addr stable throughout. Assert if_flush in cycle 2 → memory still returns data, no if_ack, if_rdata unchanged, next grant proceeds normally.
- Store dm_we=1, dm_be=4'b0011, wdata 0x1234ABCD, addr 0x200 → mem_* fields match. dm_ack follows mem_rvalid, dm_rdata unchanged.
- Spurious mem_rvalid in IDLE and ISSUE → no ack, no state change.
